// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and decoded-digit signal bundle
//
// Groups the keypad matrix lines and the decoded key outputs.
//   rows      : row strobes, active-low one-hot (scanner -> keypad)
//   cols      : column returns, active-low, asynchronous (keypad -> scanner)
//   clr       : synchronous clear of the digit register
//   key_valid : one-cycle pulse per accepted key press
//   key_code  : hex code of the last accepted key
//   digits    : last four accepted codes, newest in [3:0]
// The master modport is the scanner side; slave is the keypad/consumer side.
interface keypad_scanner_if;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic        clr;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] digits;

   modport master (
      output rows, key_valid, key_code, digits,
      input  cols, clr
   );

   modport slave (
      input  rows, key_valid, key_code, digits,
      output cols, clr
   );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with scan-level debounce
//
// Drives one keypad row low per row period, samples the synchronized column
// lines once per row, and reduces each full scan to a single result (the
// lowest-index pressed key, or none). Results are debounced over whole
// scans; accepted codes are shifted into a 16-bit, four-digit register.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   kp    : keypad_scanner_if.master (rows, cols, clr, key_valid,
//           key_code, digits)
module keypad_scanner #(
   parameter int SCAN_DIV = 4096,  // clk cycles per row period, >= 4
   parameter int DEBOUNCE = 4      // matching scans to accept/release, >= 1
) (
   input  logic             clk,
   input  logic             rst_n,
   keypad_scanner_if.master kp
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_N    = CW'(DEBOUNCE);

   typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD} state_t;

   logic [3:0]    cols_s1, cols_s2;
   logic [DW-1:0] div;
   logic [1:0]    row_idx;
   logic          sample, scan_end;

   // best hit found in the rows already sampled during the current scan
   logic          acc_hit;
   logic [3:0]    acc_code;
   logic          row_hit, res_hit;
   logic [3:0]    row_code, res_code;

   state_t        state, state_n;
   logic [3:0]    cand, cand_n;
   logic [CW-1:0] cnt, cnt_n, rel, rel_n;
   logic          accept;
   logic          key_valid_q;
   logic [3:0]    key_code_q, key_code_n;
   logic [15:0]   digits_q, digits_n;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'd0:  key_map = 4'h1;
         4'd1:  key_map = 4'h2;
         4'd2:  key_map = 4'h3;
         4'd3:  key_map = 4'hA;
         4'd4:  key_map = 4'h4;
         4'd5:  key_map = 4'h5;
         4'd6:  key_map = 4'h6;
         4'd7:  key_map = 4'hB;
         4'd8:  key_map = 4'h7;
         4'd9:  key_map = 4'h8;
         4'd10: key_map = 4'h9;
         4'd11: key_map = 4'hC;
         4'd12: key_map = 4'hE;
         4'd13: key_map = 4'h0;
         4'd14: key_map = 4'hF;
         default: key_map = 4'hD;
      endcase
   endfunction

   assign sample   = (div == DIV_LAST);
   assign scan_end = sample && (row_idx == 2'd3);

   // Lowest column in the driven row wins; iterate downward so it is written last.
   always_comb begin
      row_hit  = 1'b0;
      row_code = 4'h0;
      for (int c = 3; c >= 0; c--) begin
         if (!cols_s2[c]) begin
            row_hit  = 1'b1;
            row_code = key_map(row_idx, 2'(c));
         end
      end
   end

   // Earlier rows take priority over the row being sampled now.
   always_comb begin
      res_hit  = row_hit;
      res_code = row_code;
      if (row_idx != 2'd0 && acc_hit) begin
         res_hit  = 1'b1;
         res_code = acc_code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cols_s1  <= 4'hF;
         cols_s2  <= 4'hF;
         div      <= '0;
         row_idx  <= 2'd0;
         acc_hit  <= 1'b0;
         acc_code <= 4'h0;
      end else begin
         cols_s1 <= kp.cols;
         cols_s2 <= cols_s1;
         if (sample) begin
            div      <= '0;
            row_idx  <= row_idx + 2'd1;
            acc_hit  <= res_hit;
            acc_code <= res_code;
         end else begin
            div <= div + DW'(1);
         end
      end
   end

   // FSM state register, also holding the accept-side registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cand        <= 4'h0;
         cnt         <= '0;
         rel         <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         digits_q    <= 16'h0000;
      end else begin
         state       <= state_n;
         cand        <= cand_n;
         cnt         <= cnt_n;
         rel         <= rel_n;
         key_valid_q <= accept;
         key_code_q  <= key_code_n;
         digits_q    <= digits_n;
      end
   end

   // FSM next state; the debounce decision is only taken at scan end
   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      rel_n   = rel;
      accept  = 1'b0;
      if (scan_end) begin
         case (state)
            S_IDLE: begin
               if (res_hit) begin
                  cand_n = res_code;
                  if (DEBOUNCE == 1) begin
                     accept  = 1'b1;
                     state_n = S_HELD;
                     cnt_n   = '0;
                     rel_n   = '0;
                  end else begin
                     cnt_n   = CW'(1);
                     state_n = S_DEB;
                  end
               end
            end
            S_DEB: begin
               if (res_hit && res_code == cand) begin
                  if ((cnt + CW'(1)) == DEB_N) begin
                     accept  = 1'b1;
                     state_n = S_HELD;
                     cnt_n   = '0;
                     rel_n   = '0;
                  end else begin
                     cnt_n = cnt + CW'(1);
                  end
               end else begin
                  // a different key is dropped, not adopted as the new candidate
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end
            end
            S_HELD: begin
               if (!res_hit) begin
                  if ((rel + CW'(1)) == DEB_N) begin
                     state_n = S_IDLE;
                     rel_n   = '0;
                  end else begin
                     rel_n = rel + CW'(1);
                  end
               end else begin
                  rel_n = '0;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // Digit register update; a clear coinciding with an accept keeps the new digit.
   always_comb begin
      key_code_n = key_code_q;
      digits_n   = digits_q;
      if (accept) begin
         key_code_n = cand_n;
         digits_n   = kp.clr ? {12'h000, cand_n} : {digits_q[11:0], cand_n};
      end else if (kp.clr) begin
         digits_n = 16'h0000;
      end
   end

   // FSM outputs
   always_comb begin
      kp.rows      = ~(4'b0001 << row_idx);
      kp.key_valid = key_valid_q;
      kp.key_code  = key_code_q;
      kp.digits    = digits_q;
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;
   localparam int SD = 4;
   localparam int DB = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [15:0] pressed = 16'h0000;   // bit r*4+c set = key at row r, col c down

   keypad_scanner_if kp();

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kp)
   );

   always #5 clk = ~clk;

   // Passive keypad: a pressed key pulls its column low while its row is driven.
   always_comb begin
      kp.cols = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kp.rows[r] && pressed[r*4+c]) kp.cols[c] = 1'b0;
   end

   logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   bit          m_held;
   int          m_rel, m_streak;
   logic [3:0]  m_cand;
   logic [3:0]  exp_code;
   logic [15:0] exp_digits;
   bit          exp_acc;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_held = 0; m_rel = 0; m_streak = 0; m_cand = 4'h0;
      exp_code = 4'h0; exp_digits = 16'h0000; exp_acc = 0;
   endtask

   // One full scan of the model: reduce the pressed set to a result, then debounce.
   task automatic model_scan(input logic [15:0] mask, input int clr_mode);
      bit hit = 0;
      logic [3:0] code = 4'h0;
      for (int i = 0; i < 16; i++)
         if (mask[i] && !hit) begin hit = 1; code = keymap[i]; end
      exp_acc = 0;
      if (m_held) begin
         if (!hit) begin
            m_rel++;
            if (m_rel == DB) begin m_held = 0; m_rel = 0; end
         end else m_rel = 0;
      end else begin
         if (!hit) m_streak = 0;
         else if (m_streak > 0 && code == m_cand) m_streak++;
         else if (m_streak > 0) m_streak = 0;
         else begin m_cand = code; m_streak = 1; end
         if (m_streak == DB) begin
            exp_acc = 1; m_held = 1; m_streak = 0; m_rel = 0;
         end
      end
      if (clr_mode == 1) exp_digits = 16'h0000;
      if (exp_acc) begin
         exp_code = m_cand;
         exp_digits = (clr_mode == 2) ? {12'h000, m_cand} : {exp_digits[11:0], m_cand};
      end else if (clr_mode == 2) exp_digits = 16'h0000;
   endtask

   // Entered at a negedge just before the first edge of a scan; returns likewise.
   // clr_mode: 0 none, 1 clr pulse mid-scan, 2 clr on the scan-end edge.
   task automatic scan(input logic [15:0] mask, input int clr_mode);
      logic [3:0] er;
      pressed = mask;
      model_scan(mask, clr_mode);
      for (int i = 1; i <= 16; i++) begin
         if (i > 1) @(negedge clk);
         kp.clr = (clr_mode == 1 && i == 8) || (clr_mode == 2 && i == 16);
         @(posedge clk);
         #1;
         er = ~(4'b0001 << ((i / 4) % 4));
         chk("rows", kp.rows, er);
         chk("key_valid", kp.key_valid, (i == 16) ? exp_acc : 1'b0);
      end
      kp.clr = 1'b0;
      chk("key_code", kp.key_code, exp_code);
      chk("digits", kp.digits, exp_digits);
      @(negedge clk);
   endtask

   task automatic press(input logic [15:0] mask, input int n_on, input int n_off);
      repeat (n_on) scan(mask, 0);
      repeat (n_off) scan(16'h0000, 0);
   endtask

   initial begin
      kp.clr = 1'b0;
      model_reset();
      #1;
      chk("rst_rows", kp.rows, 4'b1110);
      chk("rst_key_valid", kp.key_valid, 1'b0);
      chk("rst_key_code", kp.key_code, 4'h0);
      chk("rst_digits", kp.digits, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // key 6 (row1 col2)
      press(16'h0040, 3, 3);
      chk("key6_digits", kp.digits, 16'h0006);

      // 1, A, 0, D then 5
      press(16'h0001, 3, 3);
      press(16'h0008, 3, 3);
      press(16'h2000, 3, 3);
      press(16'h8000, 3, 3);
      chk("seq_digits", kp.digits, 16'h1A0D);
      press(16'h0020, 3, 3);
      chk("seq5_digits", kp.digits, 16'hA0D5);

      // bounce on key 9, then a lone 2-scan glitch
      press(16'h0400, 2, 1);
      press(16'h0400, 3, 3);
      chk("bounce_digits", kp.digits, 16'h0D59);
      press(16'h0400, 2, 3);
      chk("glitch_digits", kp.digits, 16'h0D59);

      // hold key 3, add key 7 midway, release, then press 7
      press(16'h0004, 10, 0);
      press(16'h0104, 10, 3);
      chk("hold_code", kp.key_code, 4'h3);
      press(16'h0100, 3, 3);
      chk("hold_digits", kp.digits, 16'h5937);

      // clr alone, then clr coinciding with an accept
      press(16'h0001, 3, 3);
      press(16'h0002, 3, 3);
      press(16'h0004, 3, 3);
      press(16'h0010, 3, 3);
      chk("pre_clr_digits", kp.digits, 16'h1234);
      scan(16'h0000, 1);
      chk("clr_digits", kp.digits, 16'h0000);
      press(16'h0400, 3, 3);
      scan(16'h0080, 0);
      scan(16'h0080, 0);
      scan(16'h0080, 2);
      chk("clr_acc_digits", kp.digits, 16'h000B);
      press(16'h0000, 0, 3);

      // randomized key activity against the model
      repeat (40) begin
         int kind = $urandom_range(0, 3);
         int len = $urandom_range(1, 5);
         logic [15:0] m = 16'h0000;
         if (kind != 0) m[$urandom_range(0, 15)] = 1'b1;
         if (kind == 3) m[$urandom_range(0, 15)] = 1'b1;
         repeat (len) scan(m, ($urandom_range(0, 9) == 0) ? 2 : 0);
      end
      press(16'h0000, 0, 3);

      // reset mid-debounce discards progress
      scan(16'h0020, 0);
      scan(16'h0020, 0);
      pressed = 16'h0020;
      repeat (6) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rows", kp.rows, 4'b1110);
      chk("mid_rst_key_valid", kp.key_valid, 1'b0);
      chk("mid_rst_digits", kp.digits, 16'h0000);
      chk("mid_rst_key_code", kp.key_code, 4'h0);
      pressed = 16'h0000;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      scan(16'h0020, 0);
      chk("post_rst_digits", kp.digits, 16'h0000);
      scan(16'h0020, 0);
      scan(16'h0020, 0);
      chk("post_rst_accept", kp.digits, 16'h0005);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
